// File: rtl/mmu_pkg.sv
// Shared MMU types: hash-table entry layout, walker states, Wishbone structs
// and the {ASID,VPN} slot hash.
package mmu_pkg;

  typedef struct packed {
    logic        v;
    logic [9:0]  asid;
    logic [24:0] vpn_tag;
    logic [23:0] ppn;
    logic [2:0]  rwx;
    logic        rsvd;
  } ht_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } ht_walk_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  sel;
    logic [31:0] adr;
    logic [63:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [63:0] dat;
  } wb_resp_t;

  // Folds the 25-bit VPN into 10 bits and mixes in the ASID.
  function automatic logic [9:0] ht_hash(input logic [9:0] asid, input logic [24:0] vpn);
    return vpn[9:0] ^ vpn[19:10] ^ {vpn[24:20], 5'b0} ^ asid;
  endfunction

endpackage

// File: rtl/wb_bus_interface.sv
// MMU-local Wishbone link: clock/reset plus request and response bundles.
interface wb_bus_interface (
  input logic clk,
  input logic rst
);
  import mmu_pkg::*;

  wb_req_t  req;
  wb_resp_t resp;

  modport master (input clk, input rst, output req, input resp);
  modport slave  (input clk, input rst, input req, output resp);
endinterface

// File: rtl/ht_walker_hash_idx.sv
// Combinational slot address for probe n: hash, add probe offset, wrap to
// the table size, scale to 8-byte entries.
module ht_hash_idx
  import mmu_pkg::*;
#(
  parameter logic [31:0] HT_BASE = 32'hFFF8_0000,
  parameter int          ENTRIES = 1024,
  parameter int          N_W     = 3
) (
  input  logic [9:0]     asid,
  input  logic [24:0]    vpn,
  input  logic [N_W-1:0] n,
  output logic [31:0]    adr
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [IDX_W-1:0] idx;

  // Adding in IDX_W bits gives the modulo-ENTRIES wrap for free.
  always_comb begin
    idx = IDX_W'(ht_hash(asid, vpn)) + IDX_W'(n);
    adr = HT_BASE + (32'(idx) << 3);
  end

endmodule

// File: rtl/ht_walker.sv
// Hash-table walker: on a TLB miss, reads successive table slots over
// Wishbone until a tag match, an empty slot, the probe limit, or a bus fault.
module ht_walker
  import mmu_pkg::*;
#(
  parameter logic [31:0] HT_BASE = 32'hFFF8_0000,
  parameter int          ENTRIES = 1024,
  parameter int          PROBES  = 8,
  parameter int          TIMEOUT = 63
) (
  wb_bus_interface.master bus,
  input  logic            lk_req,
  input  logic [9:0]      lk_asid,
  input  logic [24:0]     lk_vpn,
  input  logic            lk_abort,
  output logic            lk_busy,
  output logic            lk_done,
  output logic            lk_hit,
  output logic            lk_fault,
  output logic [63:0]     lk_pte
);
  localparam int N_W   = (PROBES > 1) ? $clog2(PROBES) : 1;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  ht_walk_state_e   state_q, state_d;
  logic [9:0]       asid_q, asid_d;
  logic [24:0]      vpn_q, vpn_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  ht_entry_t        entry_q, entry_d;
  logic             hit_q, hit_d;
  logic             fault_q, fault_d;
  logic [63:0]      pte_q, pte_d;
  logic [31:0]      probe_adr;
  logic             tag_match;

  ht_hash_idx #(
    .HT_BASE (HT_BASE),
    .ENTRIES (ENTRIES),
    .N_W     (N_W)
  ) u_hash_idx (
    .asid (asid_q),
    .vpn  (vpn_q),
    .n    (n_q),
    .adr  (probe_adr)
  );

  assign tag_match = entry_q.v && (entry_q.asid == asid_q) && (entry_q.vpn_tag == vpn_q);

  always_comb begin
    state_d = state_q;
    asid_d  = asid_q;
    vpn_d   = vpn_q;
    n_d     = n_q;
    tmo_d   = tmo_q;
    entry_d = entry_q;
    hit_d   = hit_q;
    fault_d = fault_q;
    pte_d   = pte_q;
    bus.req = '0;

    case (state_q)
      IDLE: begin
        if (lk_req) begin
          asid_d  = lk_asid;
          vpn_d   = lk_vpn;
          n_d     = '0;
          tmo_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.req.cyc = 1'b1;
        bus.req.stb = 1'b1;
        bus.req.sel = 8'hFF;
        bus.req.adr = probe_adr;
        // Abort outranks everything, err outranks a simultaneous ack.
        if (lk_abort) begin
          state_d = IDLE;
        end else if (bus.resp.err) begin
          hit_d   = 1'b0;
          fault_d = 1'b1;
          state_d = DONE;
        end else if (bus.resp.ack) begin
          entry_d = ht_entry_t'(bus.resp.dat);
          state_d = CHECK;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          hit_d   = 1'b0;
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      CHECK: begin
        if (lk_abort) begin
          state_d = IDLE;
        end else if (tag_match) begin
          hit_d   = 1'b1;
          fault_d = 1'b0;
          pte_d   = entry_q;
          state_d = DONE;
        end else if (!entry_q.v || (n_q == N_W'(PROBES - 1))) begin
          hit_d   = 1'b0;
          fault_d = 1'b0;
          state_d = DONE;
        end else begin
          n_d     = n_q + N_W'(1);
          tmo_d   = '0;
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus.clk) begin
    if (bus.rst) begin
      state_q <= IDLE;
      asid_q  <= '0;
      vpn_q   <= '0;
      n_q     <= '0;
      tmo_q   <= '0;
      entry_q <= '0;
      hit_q   <= 1'b0;
      fault_q <= 1'b0;
      pte_q   <= '0;
    end else begin
      state_q <= state_d;
      asid_q  <= asid_d;
      vpn_q   <= vpn_d;
      n_q     <= n_d;
      tmo_q   <= tmo_d;
      entry_q <= entry_d;
      hit_q   <= hit_d;
      fault_q <= fault_d;
      pte_q   <= pte_d;
    end
  end

  assign lk_busy  = (state_q == ISSUE) || (state_q == CHECK);
  assign lk_done  = (state_q == DONE);
  assign lk_hit   = hit_q;
  assign lk_fault = fault_q;
  assign lk_pte   = pte_q;

endmodule

// File: tb/tb_ht_walker.sv
// Bench for ht_walker: Wishbone responder with a sparse table, walk reference
// model, directed corner cases and randomized lookups.
module tb_ht_walker;
  localparam logic [31:0] HT_BASE = 32'hFFF8_0000;
  localparam int ENTRIES = 1024;
  localparam int PROBES  = 8;
  localparam int TIMEOUT = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_bus_interface bus (.clk(clk), .rst(rst));

  logic        lk_req = 1'b0;
  logic        lk_abort = 1'b0;
  logic [9:0]  lk_asid = '0;
  logic [24:0] lk_vpn = '0;
  logic        lk_busy, lk_done, lk_hit, lk_fault;
  logic [63:0] lk_pte;

  ht_walker #(
    .HT_BASE (HT_BASE),
    .ENTRIES (ENTRIES),
    .PROBES  (PROBES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .bus      (bus),
    .lk_req   (lk_req),
    .lk_asid  (lk_asid),
    .lk_vpn   (lk_vpn),
    .lk_abort (lk_abort),
    .lk_busy  (lk_busy),
    .lk_done  (lk_done),
    .lk_hit   (lk_hit),
    .lk_fault (lk_fault),
    .lk_pte   (lk_pte)
  );

  // ---------------- responder and bus monitor ----------------
  logic [63:0] mem [int];
  int  wait_cfg = 0;
  bit  never_ack = 1'b0;
  int  err_at = -1;
  int  rd_cnt = 0;
  int  wcnt = 0;
  int  cyc_hi = 0;
  int  bus_viol = 0;
  logic [31:0] adr_log [$];
  mmu_pkg::wb_resp_t resp_r = '0;
  assign bus.resp = resp_r;

  function automatic logic [63:0] mem_rd(input logic [31:0] adr);
    int idx;
    idx = int'((adr - HT_BASE) >> 3);
    return mem.exists(idx) ? mem[idx] : 64'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      resp_r <= '0;
      wcnt   <= 0;
    end else begin
      resp_r.ack <= 1'b0;
      resp_r.err <= 1'b0;
      if (bus.req.cyc && bus.req.stb && !resp_r.ack && !resp_r.err) begin
        if (!never_ack && wcnt == wait_cfg) begin
          wcnt   <= 0;
          rd_cnt <= rd_cnt + 1;
          adr_log.push_back(bus.req.adr);
          if (rd_cnt == err_at) begin
            resp_r.err <= 1'b1;
          end else begin
            resp_r.ack <= 1'b1;
            resp_r.dat <= mem_rd(bus.req.adr);
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else if (!bus.req.cyc) begin
        wcnt <= 0;
      end
    end
  end

  logic        p_ack = 1'b0;
  logic        p_cyc = 1'b0;
  logic [31:0] p_adr = '0;
  always @(posedge clk) begin
    p_ack <= bus.resp.ack;
    p_cyc <= bus.req.cyc;
    p_adr <= bus.req.adr;
    if (bus.req.cyc) begin
      cyc_hi <= cyc_hi + 1;
      if (!bus.req.stb || bus.req.we || bus.req.sel != 8'hFF || bus.req.dat != 64'd0)
        bus_viol <= bus_viol + 1;
      else if (p_ack)
        bus_viol <= bus_viol + 1;
      else if (p_cyc && bus.req.adr != p_adr)
        bus_viol <= bus_viol + 1;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          exp_reads;
  bit          exp_hit, exp_fault;
  logic [63:0] exp_pte;
  logic [31:0] exp_adr [$];

  function automatic int ref_hash(input int asid, input int vpn);
    return ((vpn % 1024) ^ ((vpn / 1024) % 1024) ^ (((vpn / 1048576) % 32) * 32) ^ asid) % ENTRIES;
  endfunction

  task automatic ref_walk(input int asid, input int vpn, input int err_k);
    int h;
    h = ref_hash(asid, vpn);
    exp_hit = 0; exp_fault = 0; exp_pte = '0; exp_reads = 0;
    exp_adr.delete();
    for (int n = 0; n < PROBES; n++) begin
      int idx;
      logic [63:0] e;
      idx = (h + n) % ENTRIES;
      exp_adr.push_back(HT_BASE + 32'(idx * 8));
      exp_reads++;
      if (n == err_k) begin
        exp_fault = 1;
        return;
      end
      e = mem.exists(idx) ? mem[idx] : 64'd0;
      if (e[63] && e[62:53] == asid[9:0] && e[52:28] == vpn[24:0]) begin
        exp_hit = 1;
        exp_pte = e;
        return;
      end
      if (!e[63]) return;
    end
  endtask

  function automatic logic [63:0] mk(input bit v, input logic [9:0] a, input logic [24:0] t);
    logic [27:0] lo;
    lo = 28'($urandom());
    return {v, a, t, lo};
  endfunction

  function automatic logic [63:0] mk_other(input logic [9:0] a, input logic [24:0] t);
    if ($urandom_range(0, 1) == 0)
      return mk(1'b1, a ^ 10'($urandom_range(1, 1023)), t);
    return mk(1'b1, a, t ^ 25'($urandom_range(1, 33554431)));
  endfunction

  // ---------------- stimulus ----------------
  bit got_done;
  int got_cycle;

  task automatic lookup(input logic [9:0] a, input logic [24:0] v);
    int c;
    @(negedge clk);
    lk_asid = a; lk_vpn = v; lk_req = 1'b1;
    @(posedge clk); #1;
    lk_req = 1'b0;
    c = 1;
    chk("busy_next", lk_busy, 1);
    got_done = 0;
    while (c < 400) begin
      if (lk_done) begin
        got_done = 1;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    got_cycle = c;
  endtask

  task automatic run(input string tag, input logic [9:0] a, input logic [24:0] v,
                     input int w, input int err_k);
    int rd0, log0, viol0, exp_cyc;
    wait_cfg = w;
    rd0 = rd_cnt; log0 = adr_log.size(); viol0 = bus_viol;
    err_at = (err_k >= 0) ? rd_cnt + err_k : -1;
    ref_walk(int'(a), int'(v), err_k);
    lookup(a, v);
    chk({tag, "_done"}, got_done, 1);
    chk({tag, "_busy_at_done"}, lk_busy, 0);
    chk({tag, "_hit"}, lk_hit, exp_hit);
    chk({tag, "_fault"}, lk_fault, exp_fault);
    if (exp_hit) chk({tag, "_pte"}, lk_pte, exp_pte);
    chk({tag, "_reads"}, rd_cnt - rd0, exp_reads);
    for (int i = 0; i < exp_adr.size(); i++)
      if (log0 + i < adr_log.size()) chk({tag, "_adr"}, adr_log[log0 + i], exp_adr[i]);
    exp_cyc = exp_fault ? exp_reads * (3 + w) : 1 + exp_reads * (3 + w);
    chk({tag, "_latency"}, got_cycle, exp_cyc);
    chk({tag, "_bus_proto"}, bus_viol - viol0, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, lk_done, 0);
    chk({tag, "_hit_hold"}, lk_hit, exp_hit);
    $display("TXN %s asid=%0h vpn=%0h w=%0d hit=%0d fault=%0d reads=%0d cyc=%0d",
             tag, a, v, w, lk_hit, lk_fault, rd_cnt - rd0, got_cycle);
    err_at = -1;
  endtask

  task automatic abort_test(input string tag, input logic [9:0] a, input logic [24:0] v,
                            input int w, input int at_cyc, input bit use_rst);
    bit seen;
    wait_cfg = w;
    @(negedge clk);
    lk_asid = a; lk_vpn = v; lk_req = 1'b1;
    @(posedge clk); #1;
    lk_req = 1'b0;
    for (int c = 1; c < at_cyc; c++) begin
      @(posedge clk); #1;
    end
    if (use_rst) rst = 1'b1; else lk_abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; lk_abort = 1'b0;
    chk({tag, "_cyc_drop"}, bus.req.cyc, 0);
    chk({tag, "_stb_drop"}, bus.req.stb, 0);
    chk({tag, "_busy"}, lk_busy, 0);
    if (use_rst) begin
      chk({tag, "_rst_hit"}, lk_hit, 0);
      chk({tag, "_rst_fault"}, lk_fault, 0);
      chk({tag, "_rst_pte"}, lk_pte, 0);
    end
    seen = lk_done;
    repeat (10) begin
      @(posedge clk); #1;
      if (lk_done) seen = 1;
    end
    chk({tag, "_no_done"}, seen, 0);
    $display("TXN %s asid=%0h vpn=%0h w=%0d cancelled_at=%0d", tag, a, v, w, at_cyc);
  endtask

  initial begin
    logic [9:0]  a;
    logic [24:0] v;
    int h, cyc0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_cyc", bus.req.cyc, 0);
    chk("rst_stb", bus.req.stb, 0);
    chk("rst_adr", bus.req.adr, 0);
    chk("rst_sel", bus.req.sel, 0);
    chk("rst_busy", lk_busy, 0);
    chk("rst_done", lk_done, 0);
    chk("rst_hit", lk_hit, 0);
    chk("rst_fault", lk_fault, 0);
    chk("rst_pte", lk_pte, 0);

    // 1: direct hit in the home slot
    a = 10'd3; v = 25'h12345; h = ref_hash(int'(a), int'(v));
    mem.delete(); mem[h] = mk(1'b1, a, v);
    run("t1_hit0", a, v, 0, -1);

    // 2: match on third probe
    a = 10'h155; v = 25'h1abcde; h = ref_hash(int'(a), int'(v));
    mem.delete();
    mem[h] = mk_other(a, v); mem[(h + 1) % ENTRIES] = mk_other(a, v);
    mem[(h + 2) % ENTRIES] = mk(1'b1, a, v);
    run("t2_probe2", a, v, 1, -1);

    // 3: home slot is the last entry, match after wrap to slot 0
    a = 10'd1023; v = 25'd0; h = ref_hash(int'(a), int'(v));
    mem.delete(); mem[h] = mk_other(a, v); mem[0] = mk(1'b1, a, v);
    run("t3_wrap", a, v, 0, -1);
    chk("t3_wrap_home", h, ENTRIES - 1);
    chk("t3_wrap_adr", adr_log[adr_log.size() - 1], HT_BASE);

    // 4: full chain of foreign tags, then an empty slot ending the chain
    a = 10'h2a; v = 25'h0777; h = ref_hash(int'(a), int'(v));
    mem.delete();
    for (int n = 0; n < PROBES + 2; n++) mem[(h + n) % ENTRIES] = mk_other(a, v);
    run("t4_exhaust", a, v, 2, -1);
    mem.delete();
    mem[h] = mk_other(a, v); mem[(h + 1) % ENTRIES] = mk_other(a, v);
    mem[(h + 2) % ENTRIES] = mk(1'b0, a, v); mem[(h + 3) % ENTRIES] = mk(1'b1, a, v);
    run("t4_empty", a, v, 0, -1);

    // 5: silent responder, then bus error on the second read
    a = 10'h0f0; v = 25'h1f00f0; h = ref_hash(int'(a), int'(v));
    mem.delete(); mem[h] = mk(1'b1, a, v);
    never_ack = 1'b1;
    cyc0 = cyc_hi;
    lookup(a, v);
    never_ack = 1'b0;
    chk("t5_tmo_done", got_done, 1);
    chk("t5_tmo_fault", lk_fault, 1);
    chk("t5_tmo_hit", lk_hit, 0);
    chk("t5_tmo_latency", got_cycle, TIMEOUT + 2);
    chk("t5_tmo_cyc_cycles", cyc_hi - cyc0, TIMEOUT + 1);
    chk("t5_tmo_cyc_low", bus.req.cyc, 0);
    $display("TXN t5_tmo asid=%0h vpn=%0h fault=%0d cyc=%0d", a, v, lk_fault, got_cycle);
    @(posedge clk); #1;
    mem.delete(); mem[h] = mk_other(a, v); mem[(h + 1) % ENTRIES] = mk(1'b1, a, v);
    run("t5_err", a, v, 0, 1);

    // 6: cancel mid-walk by abort, abort racing an ack, and reset
    a = 10'd3; v = 25'h12345; h = ref_hash(int'(a), int'(v));
    mem.delete(); mem[h] = mk(1'b1, a, v);
    abort_test("t6_abort_wait", a, v, 5, 3, 1'b0);
    run("t6_after_abort", a, v, 0, -1);
    abort_test("t6_abort_ack", a, v, 0, 2, 1'b0);
    run("t6_after_abort_ack", a, v, 1, -1);
    abort_test("t6_reset", a, v, 3, 4, 1'b1);
    run("t6_after_reset", a, v, 0, -1);

    // randomized chains
    for (int t = 0; t < 30; t++) begin
      int ek;
      a = 10'($urandom()); v = 25'($urandom());
      h = ref_hash(int'(a), int'(v));
      mem.delete();
      for (int n = 0; n < PROBES; n++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      mem[(h + n) % ENTRIES] = mk_other(a, v);
        else if (r < 8) mem[(h + n) % ENTRIES] = mk(1'b1, a, v);
        else if (r < 9) mem[(h + n) % ENTRIES] = mk(1'b0, a, v);
      end
      ek = ($urandom_range(0, 7) == 0) ? $urandom_range(0, PROBES - 1) : -1;
      run($sformatf("rnd%0d", t), a, v, $urandom_range(0, 3), ek);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
